dm_bus_bridge: RTL and testbench

Converts the core's single-cycle SRAM-style data-memory port (CS/OE/WEB/A/DI/DO) into a valid/ready request/response bus, so data memory can live behind a multi-cycle interconnect. Sits directly downstream of the core's MEM stage, in place of the DM SRAM macro. Freezes the pipeline with `cpu_stall` until the bus completes each access.

---
 rtl/dm_bridge_pkg.sv | 34 +++
 rtl/dm_bus_bridge_timeout.sv | 30 +++
 rtl/dm_bus_bridge.sv | 147 ++++++++++++++
 tb/tb_dm_bus_bridge.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_bridge_pkg.sv
// dm_bridge_pkg: shared types for the data-memory bus bridge.
// FSM state encoding, request register bundle, request builder.
package dm_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2,
    DONE = 2'd3
  } dm_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } dm_req_t;

  // Reads carry no strobes or data so the bus sees a clean payload.
  function automatic dm_req_t make_req(
    input logic [31:0] byte_addr,
    input logic        write,
    input logic [3:0]  web,
    input logic [31:0] din
  );
    dm_req_t r;
    r.addr  = byte_addr;
    r.write = write;
    r.wstrb = write ? ~web : 4'b0000;
    r.wdata = write ? din : 32'h0;
    return r;
  endfunction

endpackage

// File: rtl/dm_bus_bridge_timeout.sv
// dm_bridge_timeout: cycle counter for REQ+RSP with expiry flag.
// Only instantiated when DM_BRIDGE_TIMEOUT_EN is defined.
module dm_bridge_timeout #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // Expires on the TIMEOUT-th cycle spent in REQ/RSP.
  assign expired = en && (cnt == CW'(TIMEOUT - 1));

  // Count busy cycles, restarting at each new access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en && !expired)
      cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/dm_bus_bridge.sv
// dm_bus_bridge: SRAM-style DM port to valid/ready bus bridge.
// Optional abort timer enabled by defining DM_BRIDGE_TIMEOUT_EN.
module dm_bus_bridge
  import dm_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_cs,
  input  logic              cpu_oe,
  input  logic [3:0]        cpu_web,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_din,
  output logic [31:0]       cpu_dout,
  output logic              cpu_stall,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic [31:0]       bus_req_addr,
  output logic              bus_req_write,
  output logic [3:0]        bus_req_wstrb,
  output logic [31:0]       bus_req_wdata,
  input  logic              bus_rsp_valid,
  output logic              bus_rsp_ready,
  input  logic [31:0]       bus_rsp_rdata,
  input  logic              bus_rsp_err,
  output logic              err_flag
);

  if (TIMEOUT < 1 || ADDR_W > 30) begin : g_cfg_bad
    $error("dm_bus_bridge: unsupported parameters");
  end

  dm_state_t   state;
  dm_state_t   state_nxt;
  dm_req_t     req_q;
  logic        is_wr;
  logic        access;
  logic        busy;
  logic        start;
  logic        req_hs;
  logic        rsp_hs;
  logic        expired;
  logic [31:0] byte_addr;

  assign is_wr     = (cpu_web != 4'b1111);
  assign access    = cpu_cs && (cpu_oe || is_wr);
  assign byte_addr = 32'(cpu_addr) << 2;
  assign busy      = (state == REQ) || (state == RSP);
  assign start     = (state == IDLE) && access;
  assign req_hs    = (state == REQ) && bus_req_ready;
  assign rsp_hs    = (state == RSP) && bus_rsp_valid;

  assign bus_req_valid = (state == REQ);
  assign bus_rsp_ready = (state == RSP);
  assign bus_req_addr  = req_q.addr;
  assign bus_req_write = req_q.write;
  assign bus_req_wstrb = req_q.wstrb;
  assign bus_req_wdata = req_q.wdata;

`ifdef DM_BRIDGE_TIMEOUT_EN
  dm_bridge_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (start),
    .en      (busy),
    .expired (expired)
  );
`else
  assign expired = 1'b0;
`endif

  // Stall from detection until the response lands; DONE releases.
  always_comb begin
    cpu_stall = 1'b0;
    unique case (state)
      IDLE:    cpu_stall = access;
      REQ:     cpu_stall = 1'b1;
      RSP:     cpu_stall = 1'b1;
      DONE:    cpu_stall = 1'b0;
      default: cpu_stall = 1'b0;
    endcase
  end

  // Next state; a completing handshake beats a same-cycle expiry.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (access) state_nxt = REQ;
      REQ: begin
        if (bus_req_ready)
          state_nxt = RSP;
        else if (expired)
          state_nxt = DONE;
      end
      RSP: begin
        if (bus_rsp_valid || expired)
          state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Request register captured once per access in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      req_q <= '0;
    else if (start)
      req_q <= make_req(byte_addr, is_wr, cpu_web, cpu_din);
  end

  // Read data return; error and abort both zero read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_dout <= 32'h0;
    end else if (rsp_hs) begin
      if (!req_q.write)
        cpu_dout <= bus_rsp_err ? 32'h0 : bus_rsp_rdata;
    end else if (busy && !req_hs && expired) begin
      if (!req_q.write)
        cpu_dout <= 32'h0;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      err_flag <= 1'b0;
    else if (rsp_hs && bus_rsp_err)
      err_flag <= 1'b1;
    else if (busy && !req_hs && !rsp_hs && expired)
      err_flag <= 1'b1;
  end

endmodule

// File: tb/tb_dm_bus_bridge.sv
// tb_dm_bus_bridge: scoreboard bench for dm_bus_bridge.
// Acts as both the core and the downstream bus.
module tb_dm_bus_bridge;

`ifdef DM_BRIDGE_TIMEOUT_EN
  localparam int unsigned TO = 8;
`else
  localparam int unsigned TO = 255;
`endif

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } exp_req_t;

  logic        clk;
  logic        rst;
  logic        cpu_cs;
  logic        cpu_oe;
  logic [3:0]  cpu_web;
  logic [13:0] cpu_addr;
  logic [31:0] cpu_din;
  logic [31:0] cpu_dout;
  logic        cpu_stall;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic [31:0] bus_req_addr;
  logic        bus_req_write;
  logic [3:0]  bus_req_wstrb;
  logic [31:0] bus_req_wdata;
  logic        bus_rsp_valid;
  logic        bus_rsp_ready;
  logic [31:0] bus_rsp_rdata;
  logic        bus_rsp_err;
  logic        err_flag;

  int checks;
  int failures;
  int n_req;
  int n_req_exp;

  exp_req_t    exp_q[$];
  logic [31:0] dout_q[$];
  logic [31:0] exp_dout;
  logic        exp_err;

  dm_bus_bridge #(
    .ADDR_W  (14),
    .TIMEOUT (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_cs        (cpu_cs),
    .cpu_oe        (cpu_oe),
    .cpu_web       (cpu_web),
    .cpu_addr      (cpu_addr),
    .cpu_din       (cpu_din),
    .cpu_dout      (cpu_dout),
    .cpu_stall     (cpu_stall),
    .bus_req_valid (bus_req_valid),
    .bus_req_ready (bus_req_ready),
    .bus_req_addr  (bus_req_addr),
    .bus_req_write (bus_req_write),
    .bus_req_wstrb (bus_req_wstrb),
    .bus_req_wdata (bus_req_wdata),
    .bus_rsp_valid (bus_rsp_valid),
    .bus_rsp_ready (bus_rsp_ready),
    .bus_rsp_rdata (bus_rsp_rdata),
    .bus_rsp_err   (bus_rsp_err),
    .err_flag      (err_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cpu_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cpu_cs  = 1'b0;
      cpu_oe  = 1'b0;
      cpu_web = 4'b1111;
      #1;
      chk("idle_valid", 32'(bus_req_valid), 32'd0);
      chk("idle_stall", 32'(cpu_stall), 32'd0);
    end
  endtask

  // One core access; the bus side waits rwait cycles before ready.
  task automatic access(
    input logic        wr,
    input logic [3:0]  web,
    input logic [13:0] a,
    input logic [31:0] d,
    input logic [31:0] rd,
    input logic        er,
    input int          rwait,
    input int          exp_stall,
    input logic        abort
  );
    exp_req_t e;
    int       n;
    int       w;
    bit       done;
    @(negedge clk);
    cpu_cs   = 1'b1;
    cpu_oe   = !wr;
    cpu_web  = web;
    cpu_addr = a;
    cpu_din  = d;
    e.addr   = {16'h0, a, 2'b00};
    e.write  = wr;
    e.wstrb  = wr ? ~web : 4'b0000;
    e.wdata  = wr ? d : 32'h0;
    exp_q.push_back(e);
    if (abort) begin
      if (!wr) exp_dout = 32'h0;
      exp_err = 1'b1;
    end else begin
      if (!wr) exp_dout = er ? 32'h0 : rd;
      if (er) exp_err = 1'b1;
    end
    dout_q.push_back(exp_dout);
    if (!abort) n_req_exp++;
    n = 0;
    w = 0;
    done = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      #1;
      if (cpu_stall) n++;
      else done = 1;
      if (bus_req_valid && !done) begin
        if (exp_q.size() == 0) begin
          chk("extra_req", 32'd1, 32'd0);
          bus_req_ready = 1'b0;
        end else begin
          chk("req_addr", bus_req_addr, exp_q[0].addr);
          chk("req_write", 32'(bus_req_write),
              32'(exp_q[0].write));
          chk("req_wstrb", 32'(bus_req_wstrb),
              32'(exp_q[0].wstrb));
          chk("req_wdata", bus_req_wdata, exp_q[0].wdata);
          if (w >= rwait) begin
            bus_req_ready = 1'b1;
            void'(exp_q.pop_front());
            n_req++;
          end else begin
            bus_req_ready = 1'b0;
          end
          w++;
        end
      end else begin
        bus_req_ready = 1'b0;
      end
      bus_rsp_valid = bus_rsp_ready && !done;
      bus_rsp_rdata = rd;
      bus_rsp_err   = er;
      if (!done) @(negedge clk);
    end
    if (!done) chk("stall_timeout", 32'd1, 32'd0);
    if (abort && exp_q.size() != 0) void'(exp_q.pop_front());
    chk("stall_cycles", 32'(n), 32'(exp_stall));
    chk("done_valid", 32'(bus_req_valid), 32'd0);
    chk("cpu_dout", cpu_dout, dout_q.pop_front());
    chk("err_flag", 32'(err_flag), 32'(exp_err));
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    n_req     = 0;
    n_req_exp = 0;
    exp_dout  = 32'h0;
    exp_err   = 1'b0;
    rst           = 1'b0;
    cpu_cs        = 1'b0;
    cpu_oe        = 1'b0;
    cpu_web       = 4'b1111;
    cpu_addr      = '0;
    cpu_din       = '0;
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b0;
    bus_rsp_rdata = '0;
    bus_rsp_err   = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(bus_req_valid), 32'd0);
    chk("rst_rsp_ready", 32'(bus_rsp_ready), 32'd0);
    chk("rst_dout", cpu_dout, 32'h0);
    chk("rst_err", 32'(err_flag), 32'd0);
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    chk("rst_addr", bus_req_addr, 32'h0);
    rst = 1'b1;
    cpu_idle(2);

    // zero-wait read
    access(1'b0, 4'b1111, 14'h0010, 32'h0,
           32'h1234_5678, 1'b0, 0, 3, 1'b0);
    cpu_idle(1);
    // byte write with 5 wait cycles
    access(1'b1, 4'b1110, 14'h0123, 32'hAABB_CCDD,
           32'hFFFF_FFFF, 1'b0, 5, 8, 1'b0);
    cpu_idle(1);
    // read with bus error
    access(1'b0, 4'b1111, 14'h0200, 32'h0,
           32'h5555_5555, 1'b1, 0, 3, 1'b0);
    // top word address, good read, error stays
    access(1'b0, 4'b1111, 14'h3FFF, 32'h0,
           32'hDEAD_BEEF, 1'b0, 2, 5, 1'b0);
    // back-to-back read then full write
    access(1'b0, 4'b1111, 14'h0004, 32'h0,
           32'h0BAD_F00D, 1'b0, 0, 3, 1'b0);
    access(1'b1, 4'b0000, 14'h0005, 32'h1357_9BDF,
           32'h0, 1'b0, 1, 4, 1'b0);
    cpu_idle(2);
    chk("req_count", 32'(n_req), 32'(n_req_exp));

    // reset while waiting in RSP
    @(negedge clk);
    cpu_cs   = 1'b1;
    cpu_oe   = 1'b1;
    cpu_web  = 4'b1111;
    cpu_addr = 14'h0022;
    @(negedge clk);
    #1;
    chk("mid_req_valid", 32'(bus_req_valid), 32'd1);
    bus_req_ready = 1'b1;
    @(negedge clk);
    bus_req_ready = 1'b0;
    #1;
    chk("mid_rsp_ready", 32'(bus_rsp_ready), 32'd1);
    cpu_cs = 1'b0;
    cpu_oe = 1'b0;
    rst    = 1'b0;
    #1;
    chk("arst_valid", 32'(bus_req_valid), 32'd0);
    chk("arst_rsp_ready", 32'(bus_rsp_ready), 32'd0);
    chk("arst_stall", 32'(cpu_stall), 32'd0);
    chk("arst_dout", cpu_dout, 32'h0);
    chk("arst_err", 32'(err_flag), 32'd0);
    exp_dout = 32'h0;
    exp_err  = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    cpu_idle(1);
    access(1'b0, 4'b1111, 14'h0031, 32'h0,
           32'hCAFE_0001, 1'b0, 0, 3, 1'b0);

`ifdef DM_BRIDGE_TIMEOUT_EN
    access(1'b0, 4'b1111, 14'h0040, 32'h0,
           32'h7777_7777, 1'b0, 10000, 9, 1'b1);
    cpu_idle(1);
`endif

    cpu_idle(2);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
